// File: rtl/conf_int_mul_sched_pkg.sv
// Shared types and constants for the
// configurable-precision multiplier scheduler.
package conf_int_mul_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  localparam int MUL_LAT = 2;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conf_int_mul_sched_rr_arb.sv
// Round-robin arbiter: first valid requester
// at or after the pointer, as one-hot and index.
module rr_arb
  import conf_int_mul_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = tag_w(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_c;

  // N is a power of two, so IW-bit addition wraps
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = '0;
    for (int k = 0; k < N; k++) begin
      w_c = i_ptr + IW'(k);
      if (!o_any && i_valid[w_c]) begin
        o_any      = 1'b1;
        o_idx      = w_c;
        o_gnt[w_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conf_int_mul_sched.sv
// Shares one two-stage multiplier among N_REQ requesters,
// draining the pipeline before any precision change.
module conf_int_mul_sched
  import conf_int_mul_sched_pkg::*;
#(
  parameter int N_REQ              = 4,
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  localparam int IW = tag_w(N_REQ)
) (
  input  logic clk,
  input  logic racc,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [N_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
  input  logic [N_REQ-1:0] req_apx,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_b,
  output logic mul_racc,
  output logic mul_rapx,
  input  logic [DATA_PATH_BITWIDTH-1:0] mul_d,
  output logic rsp_valid,
  output logic [IW-1:0] rsp_id,
  output logic rsp_apx,
  output logic [DATA_PATH_BITWIDTH-1:0] rsp_data,
  output logic busy
);

  localparam int DW = DATA_PATH_BITWIDTH;

  if (OP_BITWIDTH < 1 ||
      OP_BITWIDTH > DATA_PATH_BITWIDTH)
  begin : g_bad_width
    $error("OP_BITWIDTH out of range");
  end

  state_e r_state;
  logic   r_mode;
  logic   r_tgt_apx;
  logic [IW-1:0] r_ptr;

  logic [MUL_LAT-1:0]         r_tv;
  logic [MUL_LAT-1:0]         r_ta;
  logic [MUL_LAT-1:0][IW-1:0] r_tid;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_apx;
  logic             w_issue;

  rr_arb #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // r_mode = 1 is accurate, so a match means apx != mode
  assign w_apx   = req_apx[w_idx];
  assign w_issue = (r_state == ST_RUN) && w_any &&
                   (w_apx != r_mode);

  assign req_ready = {N_REQ{w_issue}} & w_gnt;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_issue && w_gnt[k]) begin
        mul_a = req_a[k*DW +: DW];
        mul_b = req_b[k*DW +: DW];
      end
    end
  end

  assign mul_racc = racc;
  assign mul_rapx = racc & r_mode;

  assign rsp_valid = r_tv[MUL_LAT-1];
  assign rsp_apx   = rsp_valid & r_ta[MUL_LAT-1];
  assign rsp_id    = rsp_valid ? r_tid[MUL_LAT-1] : '0;
  assign rsp_data  = rsp_valid ? mul_d : '0;

  assign busy = (r_state != ST_RUN) | (|r_tv);

  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      r_state   <= ST_RUN;
      r_mode    <= 1'b1;
      r_tgt_apx <= 1'b0;
      r_ptr     <= '0;
      r_tv      <= '0;
      r_ta      <= '0;
      r_tid     <= '0;
    end else begin
      r_tv  <= {r_tv[MUL_LAT-2:0], w_issue};
      r_ta  <= {r_ta[MUL_LAT-2:0],
                w_issue & w_apx};
      r_tid <= {r_tid[MUL_LAT-2:0],
                w_issue ? w_idx : IW'(0)};
      unique case (r_state)
        ST_RUN: begin
          if (w_issue) begin
            r_ptr <= w_idx + IW'(1);
          end else if (w_any) begin
            // freeze on the winner so it issues first after the switch
            r_ptr     <= w_idx;
            r_tgt_apx <= w_apx;
            r_state   <= (|r_tv) ? ST_DRAIN
                                 : ST_SWITCH;
          end
        end
        ST_DRAIN: begin
          if (~|r_tv) r_state <= ST_SWITCH;
        end
        ST_SWITCH: begin
          r_mode  <= ~r_tgt_apx;
          r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/conf_int_mul_sched.md
# conf_int_mul_sched

Round-robin scheduler that shares one registered configurable-precision integer multiplier (two-stage: operand flops, then result flops, with accurate/approximate bit-slice resets) among `N_REQ` requesters. It selects per-request precision by driving the multiplier's approximate-slice reset. It never lets a precision change overlap an in-flight operation. It sits between requesting datapath units and a single multiplier instance.

## Interface
- `N_REQ`, 4: number of requesters (power of two, ≥2).
- `OP_BITWIDTH`, 16: high (accurate) slice width of the multiplier.
- `DATA_PATH_BITWIDTH`, 16: operand/result width.
- `clk`  in  1  single clock, rising edge.
- `racc`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request; must stay high with stable payload until its `req_ready` pulse.
- `req_ready`  out  N_REQ  one-hot issue pulse; a request is accepted on the edge where valid & ready.
- `req_a`, `req_b`  in  N_REQ*DATA_PATH_BITWIDTH  packed operands, requester i at slice i.
- `req_apx`  in  N_REQ  1 = approximate (low slice forced to zero), 0 = accurate.
- `mul_a`, `mul_b`  out  DATA_PATH_BITWIDTH  operands to the multiplier; zero when no issue.
- `mul_racc`  out  1  = `racc`.
- `mul_rapx`  out  1  = `racc & mode_q`. `mode_q` = 1 means accurate.
- `mul_d`  in  DATA_PATH_BITWIDTH  multiplier result.
- `rsp_valid`  out  1  result for one issued request; no backpressure.
- `rsp_id`  out  log2(N_REQ)  requester index of the result.
- `rsp_apx`  out  1  precision of the result.
- `rsp_data`  out  DATA_PATH_BITWIDTH  = `mul_d` while `rsp_valid`, else 0.
- `busy`  out  1  high when not in RUN or any pipeline stage is valid.

## Operation
- Reset values:
  - state RUN, `mode_q`=1 (accurate), round-robin pointer 0, pipeline tags clear.
  - All outputs 0, except `mul_racc` follows `racc`.
- Pipeline tag shift register, 2 stages {valid, id, apx}:
  - Stage0 is loaded on each issue edge.
  - Stage1 is loaded from stage0.
  - `rsp_*` are driven from stage1.
- Arbitration: round-robin over `req_valid`, starting at pointer. The winner is evaluated every RUN cycle.
- State RUN:
  - If there is no winner, do nothing.
  - If winner `req_apx` == ~`mode_q`: assert `req_ready[winner]`, drive `mul_a`/`mul_b` from the winner's slices, load stage0, set pointer = winner+1 mod N_REQ.
  - If precision mismatches: no issue, pointer frozen at the winner, go to DRAIN.
- State DRAIN: no issue. When stage0 and stage1 are both invalid, go to SWITCH.
- State SWITCH: no issue. `mode_q` ← ~winner `req_apx`. Go to RUN. The frozen pointer guarantees the same requester issues next.
- At most one precision change per drain. Mixed streams are served fairly, with no starvation.
- Approximate result: operand low `DATA_PATH_BITWIDTH-OP_BITWIDTH` bits and result low bits are zero. The product is truncated to `DATA_PATH_BITWIDTH` bits, no saturation.
- `OP_BITWIDTH == DATA_PATH_BITWIDTH`: precision has no effect, but the DRAIN/SWITCH sequence still occurs on an `apx` change.
- `req_valid` dropped before ready is a protocol violation. The behaviour is then undefined.

## Timing
- Issue edge E: response is valid in the cycle after edge E+1, i.e. 2-cycle latency. Responses come in issue order.
- Back-to-back issue, one per cycle, for the same precision.
- Precision switch penalty:
  - DRAIN lasts 0–2 cycles (2 cycles if an issue happened on the edge entering DRAIN).
  - SWITCH lasts 1 cycle.
  - `mul_rapx` is stable for at least one full cycle before the next issue edge.
- Async `racc` low mid-operation:
  - Immediate return to reset state.
  - In-flight operations are discarded, with no response.
  - `mul_rapx` and `mul_racc` go low combinationally.
- Simultaneous requests: only the winner's `req_ready` is asserted. The others wait.

## Structure
- Shared package `conf_int_mul_sched_pkg`:
  - state encodings RUN/DRAIN/SWITCH,
  - `MUL_LAT`=2,
  - tag-field width function (clog2).
- One sub-module `rr_arb`, which takes valid vector and pointer and returns a one-hot grant and an index. Everything else is in `conf_int_mul_sched`.

## Test plan
- Single accurate request:
  - Stimulus: req0, a=3, b=5, apx=0, `OP_BITWIDTH`=12, `DATA_PATH_BITWIDTH`=16.
  - Required response: `req_ready[0]` at edge E. In the cycle after E+1: `rsp_valid`=1, id=0, apx=0, data=0x000F.
- Four simultaneous accurate requests:
  - Stimulus: all four requesters valid with accurate precision.
  - Required response: grants in order 0,1,2,3 on consecutive edges, then 4 consecutive responses with ids 0–3 and correct products.
- Approximate request from reset:
  - Stimulus: req2, a=0x0013, b=0x0021, apx=1.
  - Required response:
    - State sequence DRAIN(0 cycles) → SWITCH → RUN.
    - `mul_rapx` goes low one cycle before issue.
    - Response data=0x0200, apx=1, id=2. The accurate value would be 0x0273.
- Mixed precision with same operands:
  - Stimulus: req0 accurate and req1 approximate, both with a=0x0013, b=0x0021, valid together.
  - Required response: req0 issues and returns 0x0273 unaffected. Then DRAIN lasts 2 cycles, SWITCH 1 cycle, and req1 returns 0x0200.
- Reset mid-flight:
  - Stimulus: `racc` low one cycle after an issue.
  - Required response: no `rsp_valid`. After release, `mode_q`=1, pointer 0, and the next request is served normally.
- Fairness under mixed precision:
  - Stimulus: req1 alternating `apx` under continuous load from req0 and req3 (accurate).
  - Required response: every requester is granted within N_REQ grants, and no response is lost or reordered.
